instr_fetcher: RTL
==================

// Module: instr_fetcher
// PURPOSE
//  Front end of the out-of-order core. Owns the PC, fetches 32-bit words through the memory controller,
//  predecodes branch/JAL with a 2-bit BHT, buffers fetched words in an instruction queue, and delivers them
//  to the Decoder over the update_instr_* handshake. Redirects on jump_wrong from the ROB.
// PARAMETERS
//  IQ_DEPTH_LOG  2   log2 of instruction-queue depth (IQ_DEPTH = 4)
//  BHT_IDX       6   BHT index width; 64 x 2-bit counters indexed by pc[BHT_IDX+1:2]
// PORTS
//  clk                            in   1   clock, all state on rising edge
//  rst                            in   1   reset, asynchronous, active-low
//  rdy                            in   1   global enable; 0 freezes all state
//  jump_wrong                     in   1   ROB misprediction redirect
//  jump_wrong_pc                  in   32  redirect target PC
//  ROB_bp_update                  in   1   commit of a conditional branch
//  ROB_bp_pc                      in   32  PC of that branch
//  ROB_bp_taken                   in   1   actual outcome
//  IF_mem_req                     out  1   fetch request to memory controller
//  IF_mem_addr                    out  32  word address of the request
//  mem_IF_valid                   in   1   one-cycle pulse: mem_IF_instr holds the requested word
//  mem_IF_instr                   in   32  fetched word
//  update_instr_valid             out  1   queue head valid
//  update_instr                   out  32  queue head instruction
//  update_instr_isjump            out  1   1 = fetch followed the taken path
//  update_instr_jump_wrong_to_pc  out  32  PC of the path not followed
//  Decoder_not_ready_accept       in   1   Decoder cannot accept this cycle
// BEHAVIOUR
//  Reset: pc=0, queue empty, FSM=IDLE, IF_mem_req=0, IF_mem_addr=0, update_instr_valid=0, other
//   update_* outputs 0, all BHT counters=2'b01 (weakly not-taken).
//  rdy=0: no state changes (reset still acts). ROB asserts jump_wrong only with rdy=1.
//  Transfer to Decoder: update_instr_valid & !Decoder_not_ready_accept & rdy & !jump_wrong. Head pops
//   on that edge. update_* driven combinationally from the queue head; valid = (count != 0).
//  Memory handshake: IF_mem_req is registered. Once high, it and IF_mem_addr stay stable until the edge
//   that samples mem_IF_valid. At most one request is outstanding.
//  FSM:
//   IDLE: count < IQ_DEPTH -> IF_mem_req<=1, IF_mem_addr<=pc, go WAIT.
//   WAIT: on mem_IF_valid, push {instr, isjump, alt_pc} and set pc<=next_pc.
//         count_after = count + 1 - pop. If count_after < IQ_DEPTH, stay WAIT and issue next_pc on the
//         same edge (back-to-back fetch). Otherwise IF_mem_req<=0, go IDLE.
//   DROP: request was orphaned by a flush; IF_mem_req stays high on the old address. On mem_IF_valid,
//         discard the word, IF_mem_req<=0, go IDLE.
//  Predecode of the fetched word w at address p (opcode = w[6:0]):
//   7'd111 JAL: target = p + sext({w[31],w[19:12],w[20],w[30:21],1'b0});
//               next_pc=target, isjump=1, alt=p+4.
//   7'd99 branch: target = p + sext({w[31],w[7],w[30:25],w[11:8],1'b0}).
//                 If BHT[p] >= 2: next_pc=target, isjump=1, alt=p+4.
//                 Else: next_pc=p+4, isjump=0, alt=target.
//   other (incl. JALR): next_pc=p+4, isjump=0, alt=p+4. The ROB resolves JALR via jump_wrong.
//   All PC arithmetic is 32-bit and wraps modulo 2^32.
//  BHT: on ROB_bp_update, counter[ROB_bp_pc[BHT_IDX+1:2]] saturating-increments if taken, else
//   saturating-decrements (range 0..3). A same-edge update and read of one entry reads the old value.
//  jump_wrong (rdy=1): queue flushed (count=0, valid low next cycle), pc<=jump_wrong_pc, no pop.
//   IDLE -> IDLE.
//   WAIT, no mem_IF_valid this cycle -> DROP.
//   WAIT, mem_IF_valid this cycle -> word discarded, IF_mem_req<=0, IDLE.
//   DROP -> DROP; a concurrent valid is consumed as the orphan -> IDLE.
//   The redirected fetch issues from IDLE on the following cycle.
//  Queue is a circular buffer; pointers wrap modulo IQ_DEPTH. A push is never attempted when full.
//  Reset asserted mid-request: everything returns to reset values asynchronously. A later stale
//   mem_IF_valid seen in IDLE is ignored.
// TESTING
//  1 Release rst; memory returns ADDI at 0x0,0x4,0x8 -> Decoder sees them in order; isjump=0;
//    alt=0x4,0x8,0xC; IF_mem_addr sequence 0x0,0x4,0x8,0xC with back-to-back requests.
//  2 JAL x1,+0x20 at 0x10 -> isjump=1, alt=0x14; the next IF_mem_addr is 0x30.
//  3 BEQ -8 at 0x40 with cold BHT -> isjump=0, alt=0x38, next addr 0x44. Then apply 2x ROB_bp_update
//    (pc=0x40, taken=1) and jump_wrong to 0x40 -> isjump=1, alt=0x44, next addr 0x38.
//  4 Hold Decoder_not_ready_accept=1 -> after 4 responses IF_mem_req=0 and valid stays 1.
//    Release -> one pop per cycle and fetch resumes at the 5th PC.
//  5 jump_wrong to 0x100 while WAIT on 0x20 -> valid=0 next cycle; the orphan 0x20 word is never
//    presented; the next request addr is 0x100.
//  6 Assert rst mid-request -> IF_mem_req=0 and valid=0 immediately; after release the first
//    request is to 0x0.

Source files
------------

// File: rtl/instr_fetcher_if.sv
// Fetch-side bus bundle: ROB redirect and BHT training, memory request/response, decoder delivery.
// master = fetcher side, slave = environment (ROB, memory controller, decoder).
interface instr_fetcher_if;
  logic        jump_wrong;
  logic [31:0] jump_wrong_pc;
  logic        ROB_bp_update;
  logic [31:0] ROB_bp_pc;
  logic        ROB_bp_taken;
  logic        IF_mem_req;
  logic [31:0] IF_mem_addr;
  logic        mem_IF_valid;
  logic [31:0] mem_IF_instr;
  logic        update_instr_valid;
  logic [31:0] update_instr;
  logic        update_instr_isjump;
  logic [31:0] update_instr_jump_wrong_to_pc;
  logic        Decoder_not_ready_accept;

  modport master (
    input  jump_wrong, jump_wrong_pc, ROB_bp_update, ROB_bp_pc, ROB_bp_taken,
    input  mem_IF_valid, mem_IF_instr, Decoder_not_ready_accept,
    output IF_mem_req, IF_mem_addr,
    output update_instr_valid, update_instr, update_instr_isjump, update_instr_jump_wrong_to_pc
  );

  modport slave (
    output jump_wrong, jump_wrong_pc, ROB_bp_update, ROB_bp_pc, ROB_bp_taken,
    output mem_IF_valid, mem_IF_instr, Decoder_not_ready_accept,
    input  IF_mem_req, IF_mem_addr,
    input  update_instr_valid, update_instr, update_instr_isjump, update_instr_jump_wrong_to_pc
  );
endinterface

// File: rtl/instr_fetcher.sv
// Instruction fetch: PC owner, one-outstanding memory fetch with BHT/JAL predecode, 4-deep queue to decoder.
// Word reaches decoder the cycle after its response; a full queue stops fetching, the decoder stalls via not_ready.
module instr_fetcher #(
  parameter int IQ_DEPTH_LOG = 2,
  parameter int BHT_IDX      = 6
) (
  input logic            clk,
  input logic            rst,
  input logic            rdy,
  instr_fetcher_if.master bus
);
  localparam int IQ_DEPTH    = 1 << IQ_DEPTH_LOG;
  localparam int CW          = IQ_DEPTH_LOG + 1;
  localparam int BHT_ENTRIES = 1 << BHT_IDX;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(IQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        isjump;
    logic [31:0] alt;
  } iq_entry_t;

  state_t                  state, state_nxt;
  iq_entry_t               iq [IQ_DEPTH];
  logic [IQ_DEPTH_LOG-1:0] head, tail;
  logic [CW-1:0]           count, count_after;
  logic [1:0]              bht [BHT_ENTRIES];
  logic [31:0]             pc;
  logic                    mem_req, mem_req_nxt;
  logic [31:0]             mem_addr, mem_addr_nxt;

  logic        iq_vld, pop, push, jw;
  logic [31:0] w, seq_pc, jal_tgt, br_tgt;
  logic [31:0] pd_next, pd_alt;
  logic        pd_isjump;
  logic [1:0]  bht_rd;
  logic        unused_bp_pc;

  assign unused_bp_pc = &{1'b0, bus.ROB_bp_pc[31:BHT_IDX+2], bus.ROB_bp_pc[1:0], mem_addr[1:0]};

  // Predecode operates on the word returning for the address currently on the bus.
  assign w       = bus.mem_IF_instr;
  assign seq_pc  = mem_addr + 32'd4;
  assign jal_tgt = mem_addr + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  assign br_tgt  = mem_addr + {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign bht_rd  = bht[mem_addr[BHT_IDX+1:2]];

  always_comb begin
    pd_next   = seq_pc;
    pd_alt    = seq_pc;
    pd_isjump = 1'b0;
    case (w[6:0])
      7'd111: begin
        pd_next   = jal_tgt;
        pd_isjump = 1'b1;
      end
      7'd99: begin
        if (bht_rd[1]) begin
          pd_next   = br_tgt;
          pd_isjump = 1'b1;
        end else begin
          pd_alt = br_tgt;
        end
      end
      default: ;
    endcase
  end

  assign iq_vld      = (count != '0);
  assign jw          = rdy & bus.jump_wrong;
  assign pop         = iq_vld & ~bus.Decoder_not_ready_accept & rdy & ~bus.jump_wrong;
  assign push        = rdy & ~bus.jump_wrong & (state == WAIT) & bus.mem_IF_valid;
  assign count_after = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rdy) begin
      case (state)
        IDLE: if (!jw && count < DEPTH_CNT) state_nxt = WAIT;
        WAIT: begin
          if (jw)                     state_nxt = bus.mem_IF_valid ? IDLE : DROP;
          else if (bus.mem_IF_valid)  state_nxt = (count_after < DEPTH_CNT) ? WAIT : IDLE;
        end
        DROP: if (bus.mem_IF_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Request/address hold until the edge that samples mem_IF_valid.
  always_comb begin
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    if (rdy) begin
      case (state)
        IDLE: begin
          if (!jw && count < DEPTH_CNT) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc;
          end
        end
        WAIT: begin
          if (bus.mem_IF_valid) begin
            if (!jw && count_after < DEPTH_CNT) mem_addr_nxt = pd_next;
            else                                mem_req_nxt  = 1'b0;
          end
        end
        DROP: if (bus.mem_IF_valid) mem_req_nxt = 1'b0;
        default: mem_req_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) iq[i] <= '0;
    end else if (rdy) begin
      if (jw) begin
        pc    <= bus.jump_wrong_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        count <= count_after;
        if (pop) head <= head + 1'b1;
        if (push) begin
          pc       <= pd_next;
          iq[tail] <= '{instr: w, isjump: pd_isjump, alt: pd_alt};
          tail     <= tail + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (rdy && bus.ROB_bp_update) begin
      if (bus.ROB_bp_taken) begin
        if (bht[bus.ROB_bp_pc[BHT_IDX+1:2]] != 2'b11)
          bht[bus.ROB_bp_pc[BHT_IDX+1:2]] <= bht[bus.ROB_bp_pc[BHT_IDX+1:2]] + 2'b01;
      end else if (bht[bus.ROB_bp_pc[BHT_IDX+1:2]] != 2'b00) begin
        bht[bus.ROB_bp_pc[BHT_IDX+1:2]] <= bht[bus.ROB_bp_pc[BHT_IDX+1:2]] - 2'b01;
      end
    end
  end

  assign bus.IF_mem_req                    = mem_req;
  assign bus.IF_mem_addr                   = mem_addr;
  assign bus.update_instr_valid            = iq_vld;
  assign bus.update_instr                  = iq_vld ? iq[head].instr  : '0;
  assign bus.update_instr_isjump           = iq_vld ? iq[head].isjump : 1'b0;
  assign bus.update_instr_jump_wrong_to_pc = iq_vld ? iq[head].alt    : '0;
endmodule
